// File: rtl/core_pkg.sv
// Shared types and defaults for the core memory arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_owner_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/core_mem_arb_sel.sv
// Winner selection between the instruction and data requesters (CORE_MEM_ARB_RR_EN: round-robin, else data first).
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller only acts on the pick while idle.
module core_mem_arb_sel
  import core_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  arb_owner_e last_owner,
  output logic       win_vld,
  output arb_owner_e win_owner
);

  // Pick the winner; on a contest, round-robin favours whoever was not served last.
  always_comb begin
    win_vld   = inst_req | data_req;
    win_owner = DATA;
`ifdef CORE_MEM_ARB_RR_EN
    if (inst_req && data_req) begin
      win_owner = (last_owner == DATA) ? INST : DATA;
    end else if (inst_req) begin
      win_owner = INST;
    end
`else
    if (!data_req) begin
      win_owner = INST;
    end
`endif
  end

`ifndef CORE_MEM_ARB_RR_EN
  // Fixed priority has no use for history; keep the port for a uniform interface.
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == DATA);
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory bus between fetch and load/store, one transaction at a time (CORE_MEM_ARB_RR_EN selects round-robin).
// Latency: grant in cycle N, earliest response N+2, next grant N+3; a lost response becomes an error after TIMEOUT_CYC cycles.
// Backpressure: requesters hold req until granted; mem_req_o and its payload hold steady until mem_grnt_i.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_grnt_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_rvalid_o,
  output logic              inst_err_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_wen_i,
  output logic              data_grnt_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_rvalid_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  input  logic              mem_grnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Cycle index (from 0) of the RESP cycle in which the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  arb_owner_e        last_owner;
  arb_owner_e        win_owner;
  logic              win_vld;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant;
  logic              resp_ok;
  logic              resp_to;

  core_mem_arb_sel u_sel (
    .inst_req   (inst_req_i),
    .data_req   (data_req_i),
    .last_owner (last_owner),
    .win_vld    (win_vld),
    .win_owner  (win_owner)
  );

  // Next state and per-cycle events; reset suppresses every grant and response.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    resp_ok = 1'b0;
    resp_to = 1'b0;
    case (state_q)
      IDLE: if (win_vld) begin
        grant   = 1'b1;
        state_d = REQ;
      end
      REQ: if (mem_grnt_i) state_d = RESP;
      RESP: begin
        // A real response beats the watchdog when both land together.
        if (mem_rvalid_i) begin
          resp_ok = 1'b1;
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          resp_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      grant   = 1'b0;
      resp_ok = 1'b0;
      resp_to = 1'b0;
    end
  end

  // State, captured request and saturating watchdog counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= INST;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= win_owner;
        addr_q  <= (win_owner == DATA) ? data_addr_i : inst_addr_i;
        wdata_q <= (win_owner == DATA) ? data_wdata_i : '0;
        wen_q   <= (win_owner == DATA) && data_wen_i;
      end
      if (state_q == REQ && mem_grnt_i) begin
        cnt_q <= '0;
      end else if (state_q == RESP && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef CORE_MEM_ARB_RR_EN
  // Remember who was served last so a contest goes the other way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner <= DATA;
    end else if (grant) begin
      last_owner <= win_owner;
    end
  end
`else
  assign last_owner = DATA;
`endif

  assign inst_grnt_o   = grant && (win_owner == INST);
  assign data_grnt_o   = grant && (win_owner == DATA);
  assign inst_rvalid_o = (resp_ok || resp_to) && (owner_q == INST);
  assign data_rvalid_o = (resp_ok || resp_to) && (owner_q == DATA);
  assign inst_err_o    = resp_to && (owner_q == INST);
  assign data_err_o    = resp_to && (owner_q == DATA);
  assign inst_rdata_o  = (rst_i || inst_err_o) ? '0 : mem_rdata_i;
  assign data_rdata_o  = (rst_i || data_err_o) ? '0 : mem_rdata_i;
  assign mem_req_o     = !rst_i && (state_q == REQ);
  assign mem_addr_o    = rst_i ? '0 : addr_q;
  assign mem_wdata_o   = rst_i ? '0 : wdata_q;
  assign mem_wen_o     = !rst_i && wen_q;
  assign busy_o        = !rst_i && (state_q != IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: transaction-level model plus directed literal checks.
// Latency: model predicts each cycle's outputs from the current inputs and the open transaction.
// Backpressure: bench requesters hold requests until granted; memory grants and responds at random.
module tb_core_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        inst_req_i, data_req_i, data_wen_i;
  logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
  logic        inst_grnt_o, inst_rvalid_o, inst_err_o;
  logic        data_grnt_o, data_rvalid_o, data_err_o;
  logic [31:0] inst_rdata_o, data_rdata_o;
  logic        mem_req_o, mem_grnt_i, mem_wen_o, mem_rvalid_i, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: an open transaction, whether memory took it, and how long it has waited.
  bit        m_act = 0, m_acc = 0, m_own = 0, m_last = 1, m_wen = 0;
  bit [31:0] m_addr = 0, m_wdata = 0;
  int        m_wait = 0;
  bit        e_ig, e_dg, e_done;

  always #5 clk = ~clk;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_grnt_o(inst_grnt_o),
    .inst_rdata_o(inst_rdata_o), .inst_rvalid_o(inst_rvalid_o), .inst_err_o(inst_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_wen_i(data_wen_i), .data_grnt_o(data_grnt_o), .data_rdata_o(data_rdata_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_grnt_i(mem_grnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mid-cycle: derive expected outputs from the model and the live inputs, then compare.
  task automatic mid();
    bit win_v, win_d, tmo;
    bit ir, dr, ie, de, bsy, mrq;
    logic [31:0] ird, drd;
    #4;
    e_ig = 0; e_dg = 0; e_done = 0;
    ir = 0; dr = 0; ie = 0; de = 0; bsy = 0; mrq = 0;
    ird = mem_rdata_i; drd = mem_rdata_i;
    if (rst_i) begin
      ird = 0; drd = 0;
    end else if (!m_act) begin
      win_v = inst_req_i || data_req_i;
`ifdef CORE_MEM_ARB_RR_EN
      win_d = (inst_req_i && data_req_i) ? !m_last : data_req_i;
`else
      win_d = data_req_i;
`endif
      e_ig = win_v && !win_d;
      e_dg = win_v && win_d;
    end else if (!m_acc) begin
      bsy = 1; mrq = 1;
    end else begin
      bsy = 1;
      tmo = !mem_rvalid_i && (m_wait + 1 >= TMO);
      e_done = mem_rvalid_i || tmo;
      ir = e_done && !m_own; dr = e_done && m_own;
      ie = tmo && !m_own;    de = tmo && m_own;
      if (ie) ird = 0;
      if (de) drd = 0;
    end
    chk("inst_grnt", inst_grnt_o, e_ig);
    chk("data_grnt", data_grnt_o, e_dg);
    chk("inst_rvalid", inst_rvalid_o, ir);
    chk("data_rvalid", data_rvalid_o, dr);
    chk("inst_err", inst_err_o, ie);
    chk("data_err", data_err_o, de);
    chk("inst_rdata", inst_rdata_o, ird);
    chk("data_rdata", data_rdata_o, drd);
    chk("busy", busy_o, bsy);
    chk("mem_req", mem_req_o, mrq);
    if (mrq) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wen", mem_wen_o, m_wen);
      if (m_wen) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    if (rst_i) begin
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_mem_wen", mem_wen_o, 0);
    end
  endtask

  // Clock edge: advance the model with the inputs seen at the edge, then move off the edge.
  task automatic adv();
    @(posedge clk);
    if (rst_i) begin
      m_act = 0; m_acc = 0; m_last = 1;
    end else if (!m_act) begin
      if (e_ig || e_dg) begin
        m_act = 1; m_acc = 0; m_own = e_dg; m_last = e_dg;
        m_addr  = e_dg ? data_addr_i : inst_addr_i;
        m_wdata = e_dg ? data_wdata_i : 32'h0;
        m_wen   = e_dg && data_wen_i;
      end
    end else if (!m_acc) begin
      if (mem_grnt_i) begin
        m_acc = 1; m_wait = 0;
      end
    end else if (e_done) begin
      m_act = 0;
    end else begin
      m_wait++;
    end
    #1;
  endtask

  task automatic quiet();
    rst_i = 0; inst_req_i = 0; data_req_i = 0; data_wen_i = 0;
    inst_addr_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_grnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; mid(); adv(); rst_i = 0;
  endtask

  int g_seq[$];
  int exp_seq[3];

  initial begin
    quiet();
    rst_i = 1;
    mem_rdata_i = 32'hCAFE_F00D;
    #1;
    mid();
    chk("reset_busy", busy_o, 0);
    chk("reset_inst_rdata", inst_rdata_o, 0);
    adv();
    quiet();
    mid();
    chk("post_reset_mem_req", mem_req_o, 0);
    adv();

    // Single instruction read, memory grants at once and answers next cycle.
    inst_req_i = 1; inst_addr_i = 32'h100;
    mid(); chk("sr_grant", inst_grnt_o, 1); adv();
    inst_req_i = 0; mem_grnt_i = 1;
    mid(); chk("sr_mem_req", mem_req_o, 1); chk("sr_mem_addr", mem_addr_o, 32'h100); adv();
    mem_grnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    mid();
    chk("sr_rvalid", inst_rvalid_o, 1);
    chk("sr_rdata", inst_rdata_o, 32'hDEADBEEF);
    chk("sr_data_rvalid", data_rvalid_o, 0);
    adv();
    mem_rvalid_i = 0;
    mid(); chk("sr_idle", busy_o, 0); adv();

    // Data write with memory grant stalled for four cycles.
    data_req_i = 1; data_wen_i = 1; data_addr_i = 32'h2000; data_wdata_i = 32'h12345678;
    mid(); chk("wr_grant", data_grnt_o, 1); adv();
    data_req_i = 0; data_wen_i = 0; data_addr_i = 32'h9; data_wdata_i = 32'h9;
    for (int i = 0; i < 5; i++) begin
      mem_grnt_i = (i == 4);
      mid();
      chk("wr_mem_req", mem_req_o, 1);
      chk("wr_mem_addr", mem_addr_o, 32'h2000);
      chk("wr_mem_wdata", mem_wdata_o, 32'h12345678);
      chk("wr_mem_wen", mem_wen_o, 1);
      adv();
    end
    mem_grnt_i = 0; mem_rvalid_i = 1;
    mid(); chk("wr_ack", data_rvalid_o, 1); chk("wr_err", data_err_o, 0); adv();
    mem_rvalid_i = 0;

    // Watchdog: no response, error on the fourth RESP cycle, late response ignored.
    data_req_i = 1; data_addr_i = 32'h3000;
    mid(); adv();
    data_req_i = 0; mem_grnt_i = 1;
    mid(); adv();
    mem_grnt_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("to_rvalid", data_rvalid_o, (i == 3));
      if (i == 3) begin
        chk("to_err", data_err_o, 1);
        chk("to_rdata", data_rdata_o, 0);
        chk("to_inst_rdata", inst_rdata_o, 32'hFFFF_FFFF);
      end
      adv();
    end
    mid(); adv();
    mem_rvalid_i = 1;
    mid(); chk("late_data_rvalid", data_rvalid_o, 0); chk("late_inst_rvalid", inst_rvalid_o, 0); adv();
    mem_rvalid_i = 0;

    // Reset while waiting for a response drops it.
    data_req_i = 1; data_addr_i = 32'h4000;
    mid(); adv();
    data_req_i = 0; mem_grnt_i = 1;
    mid(); adv();
    mem_grnt_i = 0; rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5_A5A5;
    mid();
    chk("rr_rvalid", data_rvalid_o, 0);
    chk("rr_busy", busy_o, 0);
    chk("rr_rdata", data_rdata_o, 0);
    adv();
    rst_i = 0; mem_rvalid_i = 0;
    mid(); chk("rr_idle", busy_o, 0); chk("rr_no_resp", data_rvalid_o, 0); adv();
    inst_req_i = 1; inst_addr_i = 32'h400;
    mid(); chk("rr_new_grant", inst_grnt_o, 1); adv();
    inst_req_i = 0; mem_grnt_i = 1;
    mid(); adv();
    mem_grnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    mid(); chk("rr_new_resp", inst_rvalid_o, 1); chk("rr_new_rdata", inst_rdata_o, 32'h55); adv();
    mem_rvalid_i = 0;

    // Contention with both requests held; memory fastest possible.
    do_reset();
`ifdef CORE_MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{1, 1, 1};
`endif
    inst_req_i = 1; data_req_i = 1; inst_addr_i = 32'h500; data_addr_i = 32'h600;
    mem_grnt_i = 1; mem_rvalid_i = 1;
    for (int i = 0; i < 9; i++) begin
      mid();
      if (inst_grnt_o) g_seq.push_back(0);
      if (data_grnt_o) g_seq.push_back(1);
      adv();
    end
    chk("cont_count", g_seq.size(), 3);
    for (int i = 0; i < 3 && i < g_seq.size(); i++) chk("cont_order", g_seq[i], exp_seq[i]);
    data_req_i = 0;
    mid(); chk("cont_inst_after_drop", inst_grnt_o, 1); adv();
    quiet();
    mid(); adv();
    mid(); adv();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      if (inst_req_i && !e_ig) begin
        if ($urandom_range(0, 19) == 0) inst_req_i = 0;
      end else begin
        inst_req_i = $urandom_range(0, 1);
        inst_addr_i = $urandom;
      end
      if (data_req_i && !e_dg) begin
        if ($urandom_range(0, 19) == 0) data_req_i = 0;
      end else begin
        data_req_i = $urandom_range(0, 1);
        data_addr_i = $urandom;
        data_wdata_i = $urandom;
        data_wen_i = $urandom_range(0, 1);
      end
      mem_grnt_i = $urandom_range(0, 1);
      mem_rvalid_i = ($urandom_range(0, 99) < 35);
      mem_rdata_i = $urandom;
      mid();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
